// File: rtl/operand_fetch.sv
// Operand fetch: drives regfile read ports, captures registered read data,
// and stalls intake on RAW/WAW hazards via a pending-write scoreboard.
// Ports: clk, rst_n; in* (decoded instr, valid/ready); readReg*/readData*
// (regfile read side); wb* (writeback mirror); out* (operand bundle); busy.
// Option: OPFETCH_WB_BYPASS_EN lets a same-cycle writeback release a hazard.
module operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic [4:0]  inRs1,
  input  logic [4:0]  inRs2,
  input  logic [4:0]  inRd,
  input  logic        inRdWrite,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic        wbValid,
  input  logic [4:0]  wbReg,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] outRs1Data,
  output logic [31:0] outRs2Data,
  output logic [4:0]  outRd,
  output logic        outRdWrite,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pending, pend_nxt;
  logic [31:0] pend_eff;
  logic [31:0] wbmask;
  logic        hazard;
  logic        accept;
  logic [4:0]  rd_q;
  logic        rdw_q;

  assign readReg1 = inRs1;
  assign readReg2 = inRs2;

`ifdef OPFETCH_WB_BYPASS_EN
  // regfile forwards the write data, so the retiring index is safe now
  assign wbmask = wbValid ? (32'd1 << wbReg) : 32'd0;
`else
  assign wbmask = 32'd0;
`endif

  assign pend_eff = pending & ~wbmask;
  assign hazard   = pend_eff[inRs1] | pend_eff[inRs2]
                  | (inRdWrite & pend_eff[inRd]);
  assign accept   = inValid & inReady;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):  if (accept) state_nxt = READ;
      (state == READ):  state_nxt = VALID;
      (state == VALID): if (outReady)
                          state_nxt = accept ? READ : IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    outValid = 1'b0;
    inReady  = 1'b0;
    unique case (1'b1)
      (state == IDLE):  inReady = ~hazard;
      (state == VALID): begin
        outValid = 1'b1;
        inReady  = outReady & ~hazard;
      end
      default: ;
    endcase
  end

  // set is applied after clear so a same-edge collision stays pending
  always_comb begin
    pend_nxt = pending;
    if (wbValid && wbReg != 5'd0)
      pend_nxt[wbReg] = 1'b0;
    if (accept && inRdWrite && inRd != 5'd0)
      pend_nxt[inRd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 32'd0;
      busy    <= 1'b0;
    end else begin
      pending <= pend_nxt;
      busy    <= |pend_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= 5'd0;
      rdw_q <= 1'b0;
    end else if (accept) begin
      rd_q  <= inRd;
      rdw_q <= inRdWrite;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outRs1Data <= 32'd0;
      outRs2Data <= 32'd0;
      outRd      <= 5'd0;
      outRdWrite <= 1'b0;
    end else if (state == READ) begin
      outRs1Data <= readData1;
      outRs2Data <= readData2;
      outRd      <= rd_q;
      outRdWrite <= rdw_q;
    end
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage that drives the read ports of the 32x32 register file and hands operands to execute. It accepts decoded instructions over a valid/ready handshake, presents rs1/rs2 to the regfile, and captures the registered read data one clock later. A pending-write scoreboard stalls intake on RAW and WAW hazards until the matching writeback retires.

## Interface
- No parameters; data width is fixed at 32 bits and the register count at 32.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `inValid` in 1: a decoded instruction is offered.
- `inReady` out 1: the stage accepts the offered instruction this cycle.
- `inRs1`, `inRs2` in 5 each: source register indices.
- `inRd` in 5: destination register index.
- `inRdWrite` in 1: the instruction will write `inRd`.
- `readReg1`, `readReg2` out 5 each: regfile read addresses, driven combinationally.
- `readData1`, `readData2` in 32 each: registered regfile read data, valid one clock after the address is sampled.
- `wbValid` in 1: a regfile write occurs on this edge; mirrors the regfile `write` input.
- `wbReg` in 5: index being written; mirrors the regfile `writeReg` input.
- `outValid` out 1: the output operand bundle is valid.
- `outReady` in 1: execute consumes the bundle.
- `outRs1Data`, `outRs2Data` out 32 each: captured operands.
- `outRd` out 5: registered copy of `inRd`.
- `outRdWrite` out 1: registered copy of `inRdWrite`.
- `busy` out 1: high while any scoreboard bit is set.

## Operation
- FSM states and transitions:
  - IDLE: on accept, go to READ.
  - READ: capture `readData1`/`readData2` and latched rd fields into the out registers; go to VALID.
  - VALID: `outValid`=1. On `outReady`, go to READ if a new instruction is accepted the same cycle, otherwise go to IDLE.
- `inReady` = (IDLE, or VALID with `outReady`) and no hazard.
- Accept = `inValid` && `inReady`.
- `readReg1`/`readReg2` = `inRs1`/`inRs2` at all times. On the accept edge they are the addresses the regfile samples.
- Scoreboard: `pending[31:1]`. Index 0 is never pending.
  - Set: on accept with `inRdWrite` and `inRd`≠0.
  - Clear: on `wbValid` with `wbReg`≠0.
  - If set and clear hit the same index on the same edge, set wins.
- Hazard: `pending[inRs1]`, `pending[inRs2]` or (`inRdWrite` and `pending[inRd]`) for any nonzero index.
- `wbValid` to a non-pending index has no effect on the scoreboard.
- Operand correctness relies on the regfile's same-edge write forwarding. A source is never written between its sample and capture, because the scoreboard blocks that case.
- Reset (async, any state): FSM→IDLE, scoreboard cleared, `outValid`=0, `outRs1Data`/`outRs2Data`=0, `outRd`=0, `outRdWrite`=0, `busy`=0. Any in-flight instruction is dropped.

## Timing
- Latency: accept at edge E; `outValid` rises after edge E+1.
- Maximum throughput: one instruction per 2 cycles when `outReady` is held high.
- Outputs hold stable while `outValid` && !`outReady`.
- `inReady` is combinational from state, `outReady`, `pending`, the in fields and, when configured, `wbValid`/`wbReg`. It is low during READ.
- `busy` is registered and reflects the scoreboard after each edge.

## Configuration
- `OPFETCH_WB_BYPASS_EN` defined:
  - A hazard on index r is ignored in the cycle where `wbValid` && `wbReg`==r.
  - The regfile forwards `writeData`, so accept proceeds one cycle earlier.
- Undefined:
  - The hazard check uses `pending` only.
  - Accept waits until the cycle after the writeback edge.

## Test plan
- **Basic fetch:** x1=5, x2=7; after reset, offer rs1=1, rs2=2, rd=3, rdWrite=1 → accept at E. `outValid` after E+1 with data 5/7 and outRd=3. `busy`=1 after E.
- **RAW stall:** A (rd=3, write) then B (rs1=3). Writeback of x3=0x1234 arrives 4 cycles later.
  - `inReady` stays 0 for B until that writeback.
  - With bypass: B is accepted on the `wbValid` cycle.
  - Without bypass: B is accepted one cycle later.
  - In both cases `outRs1Data`=0x1234.
- **x0 handling:** rd=0 with rdWrite=1, then rs1=0 → no stall, `busy` stays 0, `outRs1Data`=0.
- **WAW stall:** pending x5; offer rd=5, rdWrite=1 → `inReady`=0 until wbReg=5. Same-edge set/clear leaves `pending[5]`=1.
- **Backpressure:** hold `outReady`=0 for 5 cycles in VALID → outputs constant, `inReady`=0. Raising `outReady` together with `inValid` and no hazard → back-to-back accept, VALID→READ.
- **Reset mid-READ:** assert `rst_n`=0 asynchronously → immediately `outValid`=0 and `busy`=0. After release, the first offered instruction is accepted with no residual stall.
